// File: rtl/cart_pkg.sv
// Shared types and helpers for the cartridge loader: FSM state encoding,
// bank granularity and the power-of-two sizing used to derive the bank mask.
package cart_pkg;

  localparam int MIN_BANK_LOG2 = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FINISH = 3'd2,
    ST_PAD    = 3'd3,
    ST_HOLD   = 3'd4
  } cart_state_e;

  function automatic int bank_mask_w(input int addr_w);
    return addr_w - MIN_BANK_LOG2;
  endfunction

  // Smallest power of two >= n, never below one 16K bank.
  function automatic logic [31:0] ceil_pow2(input logic [31:0] n);
    logic [31:0] p;
    p = 32'd1 << MIN_BANK_LOG2;
    for (int i = 31; i >= MIN_BANK_LOG2; i--)
      if ((32'd1 << i) >= n) p = 32'd1 << i;
    return p;
  endfunction

endpackage

// File: rtl/cart_loader_if.sv
// ioctl download port and cartridge byte-write port bundled together.
// slave is the loader's view, master is the hps_io/memory side.
interface cart_loader_if #(
  parameter int ADDR_W = 19
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_busy;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_busy,
    output ioctl_wait, mem_addr, mem_din, mem_we
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_busy,
    input  ioctl_wait, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/cart_wr_port.sv
// Single-entry pending write register presented to cartridge memory;
// holds address/data/strobe until the memory accepts (we & ~busy).
module cart_wr_port
  import cart_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  input  logic              i_mem_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_din,
  output logic              o_mem_we,
  output logic              o_pending,
  output logic              o_accepted
);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              w_accepted;

  assign w_accepted = r_we && !i_mem_busy;

  // A new load wins over a same-cycle acceptance: the old byte leaves, the new one waits.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_we   <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (w_accepted) begin
      r_we   <= 1'b0;
    end
  end

  assign o_mem_addr = r_addr;
  assign o_mem_din  = r_data;
  assign o_mem_we   = r_we;
  assign o_pending  = r_we;
  assign o_accepted = w_accepted;

endmodule

// File: rtl/cart_loader.sv
// Streams an ioctl cartridge download into cart memory, holds the CPU in reset,
// then publishes image size and 16K bank mask. CART_PAD_EN enables FILL_BYTE padding to P.
module cart_loader
  import cart_pkg::*;
#(
  parameter int         ADDR_W     = 19,
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter logic [7:0] FILL_BYTE  = 8'hFF,
  parameter int         HOLD_CYC   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  cart_loader_if.slave                   bus,
  output logic [ADDR_W:0]                cart_size,
  output logic [bank_mask_w(ADDR_W)-1:0] bank_mask,
  output logic                           loaded,
  output logic                           load_err,
  output logic                           cpu_hold
);

  localparam int BM_W  = bank_mask_w(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  cart_state_e       r_state;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [HC_W-1:0]   r_hold_cnt;
  logic              r_loaded;
  logic              r_load_err;
  logic              r_cpu_hold;
  logic [CNT_W-1:0]  r_cart_size;
  logic [BM_W-1:0]   r_bank_mask;

  logic              w_start;
  logic              w_enter;
  logic              w_in_range;
  logic              w_wr_ok;
  logic              w_pending;
  logic              w_accepted;
  logic              w_load;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [7:0]        w_ld_data;
  logic [CNT_W-1:0]  w_addr_p1;
  logic [31:0]       w_pow2;

`ifdef CART_PAD_EN
  logic [ADDR_W-1:0] r_pad_ptr;
  logic [ADDR_W-1:0] r_pad_last;
  logic              r_pad_all;
`endif

  assign w_start    = bus.ioctl_download && (bus.ioctl_index == CART_INDEX);
  assign w_enter    = w_start && (r_state != ST_LOAD);
  assign w_in_range = (bus.ioctl_addr[24:ADDR_W] == '0);
  assign w_wr_ok    = (r_state == ST_LOAD) && bus.ioctl_wr && w_in_range;
  assign w_addr_p1  = {1'b0, bus.ioctl_addr[ADDR_W-1:0]} + CNT_W'(1);
  assign w_pow2     = ceil_pow2(32'(r_count));

  always_comb begin
    w_load    = w_wr_ok;
    w_ld_addr = bus.ioctl_addr[ADDR_W-1:0];
    w_ld_data = (r_state == ST_PAD) ? FILL_BYTE : bus.ioctl_dout;
`ifdef CART_PAD_EN
    if (r_state == ST_PAD) begin
      w_load    = !r_pad_all && (!w_pending || w_accepted);
      w_ld_addr = r_pad_ptr;
    end
`endif
  end

  cart_wr_port #(.ADDR_W(ADDR_W)) u_wr_port (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (w_enter),
    .i_load     (w_load),
    .i_addr     (w_ld_addr),
    .i_data     (w_ld_data),
    .i_mem_busy (bus.mem_busy),
    .o_mem_addr (bus.mem_addr),
    .o_mem_din  (bus.mem_din),
    .o_mem_we   (bus.mem_we),
    .o_pending  (w_pending),
    .o_accepted (w_accepted)
  );

  assign bus.ioctl_wait = (r_state == ST_LOAD) && w_pending;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_hold_cnt  <= '0;
      r_loaded    <= 1'b0;
      r_load_err  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_cart_size <= '0;
      r_bank_mask <= '0;
`ifdef CART_PAD_EN
      r_pad_all   <= 1'b0;
`endif
    end else if (w_enter) begin
      // Any matching download (re)starts a load, aborting FINISH/PAD/HOLD.
      r_state    <= ST_LOAD;
      r_loaded   <= 1'b0;
      r_load_err <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_wr_ok && (w_addr_p1 > r_count)) r_count <= w_addr_p1;
          if (bus.ioctl_wr && !w_in_range) r_ovf <= 1'b1;
          if (!bus.ioctl_download && !w_pending) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_cart_size <= r_count;
          r_bank_mask <= BM_W'((w_pow2 >> MIN_BANK_LOG2) - 32'd1);
          r_hold_cnt  <= '0;
          if ((r_count == '0) || r_ovf) begin
            r_load_err <= 1'b1;
            r_loaded   <= 1'b0;
            r_state    <= ST_HOLD;
          end else begin
`ifdef CART_PAD_EN
            if (32'(r_count) != w_pow2) begin
              r_pad_ptr  <= ADDR_W'(r_count);
              r_pad_last <= ADDR_W'(w_pow2 - 32'd1);
              r_pad_all  <= 1'b0;
              r_state    <= ST_PAD;
            end else begin
              r_state    <= ST_HOLD;
            end
`else
            r_state <= ST_HOLD;
`endif
          end
        end
`ifdef CART_PAD_EN
        ST_PAD: begin
          if (w_load) begin
            if (r_pad_ptr == r_pad_last) r_pad_all <= 1'b1;
            else                         r_pad_ptr <= r_pad_ptr + ADDR_W'(1);
          end
          if (r_pad_all && w_accepted) r_state <= ST_HOLD;
        end
`endif
        ST_HOLD: begin
          if (r_hold_cnt == HC_W'(HOLD_CYC - 1)) begin
            r_cpu_hold <= 1'b0;
            r_loaded   <= !r_load_err;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // hps_io must wait for ioctl_wait to clear before strobing the next byte.
  a_wr_while_pending: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_wr_ok && w_pending));

  assign cart_size = r_cart_size;
  assign bank_mask = r_bank_mask;
  assign loaded    = r_loaded;
  assign load_err  = r_load_err;
  assign cpu_hold  = r_cpu_hold;

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits between hps_io's ioctl download port and the cartridge ROM store.
- Streams the OSD-loaded cartridge image into cartridge memory through a byte-write port, with ioctl_wait back-pressure.
- Holds the CPU in reset while loading, then measures the image and publishes size and bank mask.
- The bank mask is used to mirror the sys_ctl[6:5] bank select for carts smaller than the full 64K map.

Parameters:
- ADDR_W, 19, cartridge address width in bytes (512 KiB maximum).
- CART_INDEX, 8'd1, ioctl_index value identifying a cartridge download.
- FILL_BYTE, 8'hFF, pad value (used only with CART_PAD_EN).
- HOLD_CYC, 16, cycles cpu_hold stays high after the load completes.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  synchronous reset, active low.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- mem_addr  out  ADDR_W  cartridge write address.
- mem_din  out  8  cartridge write data.
- mem_we  out  1  write strobe; a write is accepted on a cycle with mem_we=1 and mem_busy=0.
- mem_busy  in  1  memory cannot accept a write this cycle.
- cart_size  out  ADDR_W+1  byte count of the loaded image.
- bank_mask  out  ADDR_W-14  16K-bank mask = (pow2 size >> 14) - 1.
- loaded  out  1  valid image present.
- load_err  out  1  the last download was empty or oversize.
- cpu_hold  out  1  keep the CPU in reset.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs 0, including loaded, load_err, cart_size and bank_mask.
  - Any pending write is discarded.
- States: IDLE, LOAD, FINISH, PAD (only with CART_PAD_EN), HOLD.
- IDLE -> LOAD when ioctl_download=1 and ioctl_index=CART_INDEX.
  - On entry: loaded<=0, load_err<=0, byte count<=0, overflow<=0, cpu_hold<=1.
  - Downloads with any other index are ignored entirely.
- LOAD, on ioctl_wr:
  - If ioctl_addr < 2^ADDR_W: latch address and data into the pending register, set mem_we, raise ioctl_wait on the next cycle.
  - ioctl_wait stays high until the cycle the write is accepted (mem_we & ~mem_busy); it drops the cycle after.
  - If ioctl_addr >= 2^ADDR_W: the byte is dropped, overflow<=1, no wait is raised.
- Byte count = max(count, ioctl_addr+1) over all accepted bytes; order-independent.
- ioctl_wr while a write is pending: protocol violation.
  - The new byte overwrites the pending byte.
  - Verification flags it with an assertion only.
- LOAD -> FINISH on the ioctl_download falling edge, once no write is pending. If a write is pending, FINISH waits until it is accepted.
- FINISH, one cycle:
  - cart_size <= count.
  - P = smallest power of two >= count, with a floor of 16384.
  - bank_mask <= (P >> 14) - 1.
  - If count=0 or overflow: load_err<=1, loaded<=0, go to HOLD.
  - Otherwise go to PAD (if enabled) or HOLD; loaded<=1 is set on leaving HOLD.
- HOLD: counts HOLD_CYC cycles, then cpu_hold<=0, loaded<=1 if there was no error, and the state returns to IDLE.
- A new matching download asserted in FINISH, PAD or HOLD aborts the current operation and re-enters LOAD, applying the LOAD entry actions.
- Counters saturate, never wrap:
  - count saturates at 2^ADDR_W.
  - The pad pointer stops at P-1.

Optional Feature:
- Macro: CART_PAD_EN.
- Defined:
  - PAD writes FILL_BYTE to addresses count .. P-1 sequentially, one write per accepted cycle, honouring mem_busy.
  - ioctl_wait stays 0 during PAD.
  - PAD -> HOLD after address P-1 is accepted; PAD is skipped when count = P.
- Undefined:
  - PAD is not compiled in; FINISH goes straight to HOLD.
  - Memory beyond count keeps its previous contents.

Decomposition:
- Package cart_pkg holds:
  - the state enum (IDLE, LOAD, FINISH, PAD, HOLD);
  - MIN_BANK_LOG2=14;
  - the function ceil_pow2 (with floor) used for P;
  - the bank-mask width constant.
- One sub-module, cart_wr_port:
  - a single-entry pending register that drives mem_addr, mem_din and mem_we against mem_busy;
  - exposes pending/accepted to the FSM.

Test Plan:
- 32768 sequential bytes, index 1, mem_busy=0 -> 32768 writes; then cart_size=32768, bank_mask=1, loaded=1 exactly HOLD_CYC+1 cycles after FINISH, cpu_hold falls the same cycle.
- mem_busy high for 3 cycles on byte 5 -> ioctl_wait high 4 cycles, with no byte loss or duplication; memory image matches the source.
- 20000 bytes with CART_PAD_EN -> P=32768, bank_mask=1, 12768 writes of 8'hFF to 20000..32767. Without the macro: no writes after address 19999.
- Download with index 2 -> no mem_we, no ioctl_wait, and loaded keeps its prior value. Empty download with index 1 -> load_err=1, loaded=0.
- reset_n low mid-LOAD at byte 100 -> next cycle: IDLE, mem_we=0, ioctl_wait=0, loaded=0. A new download re-enters LOAD with count=0.
- Byte at address 2^19 -> dropped, load_err=1 after FINISH. A second matching download asserted during HOLD restarts LOAD.
